// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path.
//   DIGITS      : number of multiplexed digits
//   nibble_t    : one hex digit value
//   glyph_t     : active-high segment pattern {g,f,e,d,c,b,a}
//   seg7_glyph  : nibble -> glyph lookup (0-9, A, b, C, d, E, F)
package seg_pkg;

   localparam int DIGITS = 8;

   typedef logic [3:0] nibble_t;
   typedef logic [6:0] glyph_t;

   localparam glyph_t GLYPH_0 = 7'h3F;
   localparam glyph_t GLYPH_1 = 7'h06;
   localparam glyph_t GLYPH_2 = 7'h5B;
   localparam glyph_t GLYPH_3 = 7'h4F;
   localparam glyph_t GLYPH_4 = 7'h66;
   localparam glyph_t GLYPH_5 = 7'h6D;
   localparam glyph_t GLYPH_6 = 7'h7D;
   localparam glyph_t GLYPH_7 = 7'h07;
   localparam glyph_t GLYPH_8 = 7'h7F;
   localparam glyph_t GLYPH_9 = 7'h6F;
   localparam glyph_t GLYPH_A = 7'h77;
   localparam glyph_t GLYPH_B = 7'h7C;
   localparam glyph_t GLYPH_C = 7'h39;
   localparam glyph_t GLYPH_D = 7'h5E;
   localparam glyph_t GLYPH_E = 7'h79;
   localparam glyph_t GLYPH_F = 7'h71;

   function automatic glyph_t seg7_glyph(input nibble_t nib);
      glyph_t g;
      case (nib)
         4'h0:    g = GLYPH_0;
         4'h1:    g = GLYPH_1;
         4'h2:    g = GLYPH_2;
         4'h3:    g = GLYPH_3;
         4'h4:    g = GLYPH_4;
         4'h5:    g = GLYPH_5;
         4'h6:    g = GLYPH_6;
         4'h7:    g = GLYPH_7;
         4'h8:    g = GLYPH_8;
         4'h9:    g = GLYPH_9;
         4'hA:    g = GLYPH_A;
         4'hB:    g = GLYPH_B;
         4'hC:    g = GLYPH_C;
         4'hD:    g = GLYPH_D;
         4'hE:    g = GLYPH_E;
         default: g = GLYPH_F;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to 7-segment glyph decoder.
//   i_nibble : digit value 0-F
//   o_glyph  : active-high segment pattern {g,f,e,d,c,b,a}
module seg7_decode
   import seg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_glyph
);

   assign o_glyph = seg7_glyph(i_nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment display driver.
// Snapshots the digit inputs once per frame, scans one digit per slot with a
// dark guard interval at the start of each slot, and applies leading-zero
// blanking and output polarity.
//   clk, rst_n      : system clock, async active-low reset
//   seg0..seg7      : digit values, seg0 rightmost
//   dp_in           : decimal point per digit
//   blank_lz        : enable leading-zero blanking
//   dig_sel         : one-hot digit select (registered)
//   seg_out         : {dp,g,f,e,d,c,b,a} (registered)
//   frame_done      : one-cycle pulse after the digit-7 slot ends
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int SCAN_HZ     = 1_000,
   parameter int GHOST_CYC   = 16,
   parameter bit SEG_ACT_LOW = 1'b1,
   parameter bit SEL_ACT_LOW = 1'b1
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] seg0,
   input  logic [3:0] seg1,
   input  logic [3:0] seg2,
   input  logic [3:0] seg3,
   input  logic [3:0] seg4,
   input  logic [3:0] seg5,
   input  logic [3:0] seg6,
   input  logic [3:0] seg7,
   input  logic [7:0] dp_in,
   input  logic       blank_lz,
   output logic [7:0] dig_sel,
   output logic [7:0] seg_out,
   output logic       frame_done
);

   localparam int DIV = CLK_FREQ_HZ / (SCAN_HZ * DIGITS);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_GHOST = CW'(GHOST_CYC);
   // XOR masks that both express "all off" and flip active-high patterns
   localparam logic [7:0] SEL_OFF = SEL_ACT_LOW ? 8'hFF : 8'h00;
   localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;

   logic [CW-1:0]              r_count;
   logic [2:0]                 r_idx;
   logic                       r_init;
   logic [DIGITS-1:0][3:0]     r_shadow;
   logic [7:0]                 r_dp;
   logic                       r_lz;
   logic [7:0]                 r_dig_sel;
   logic [7:0]                 r_seg_out;
   logic                       r_frame_done;

   logic [DIGITS-1:0][3:0]     w_seg_in;
   logic                       w_slot_end;
   logic                       w_frame_end;
   logic                       w_snap;
   logic [6:0]                 w_glyph;
   logic [DIGITS-1:0]          w_blank;
   logic [7:0]                 w_sel_nxt;
   logic [7:0]                 w_seg_nxt;

   assign w_seg_in    = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};
   assign w_slot_end  = (r_count == CNT_LAST);
   assign w_frame_end = w_slot_end && (r_idx == 3'd7);
   // r_init gives one capture on the first edge after reset release so the
   // display does not wait a whole frame before showing live data
   assign w_snap      = r_init || w_frame_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_idx   <= '0;
         r_init  <= 1'b1;
      end else begin
         r_init <= 1'b0;
         if (w_slot_end) begin
            r_count <= '0;
            r_idx   <= r_idx + 3'd1;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
         r_dp     <= '0;
         r_lz     <= 1'b0;
      end else if (w_snap) begin
         r_shadow <= w_seg_in;
         r_dp     <= dp_in;
         r_lz     <= blank_lz;
      end
   end

   seg7_decode u_decode (
      .i_nibble (r_shadow[r_idx]),
      .o_glyph  (w_glyph)
   );

   // Digit i is blank when it and every digit to its left are zero;
   // digit 0 always shows so an all-zero value reads "0".
   always_comb begin : lz_mask
      logic w_zero_run;
      w_zero_run = 1'b1;
      w_blank    = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_zero_run = w_zero_run && (r_shadow[i] == 4'd0);
         w_blank[i] = r_lz && w_zero_run && (i != 0);
      end
   end

   always_comb begin
      w_sel_nxt = SEL_OFF;
      w_seg_nxt = SEG_OFF;
      if (r_count >= CNT_GHOST) begin
         w_sel_nxt = (8'b1 << r_idx) ^ SEL_OFF;
         w_seg_nxt = {r_dp[r_idx], (w_blank[r_idx] ? 7'h00 : w_glyph)} ^ SEG_OFF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dig_sel    <= SEL_OFF;
         r_seg_out    <= SEG_OFF;
         r_frame_done <= 1'b0;
      end else begin
         r_dig_sel    <= w_sel_nxt;
         r_seg_out    <= w_seg_nxt;
         r_frame_done <= w_frame_end;
      end
   end

   assign dig_sel    = r_dig_sel;
   assign seg_out    = r_seg_out;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: 8 kHz clock, 100 Hz frame
// (10 cycles per digit, 2 dark), active-high pins. Expected pins are derived
// from the elapsed cycle count since reset release and a per-frame snapshot
// of the inputs.
module tb_seg_scan_driver;

   localparam int DIV   = 10;
   localparam int GHOST = 2;
   localparam int FRAME = 8 * DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] seg_in [8];
   logic [7:0] dp_in;
   logic       blank_lz;
   logic [7:0] dig_sel;
   logic [7:0] seg_out;
   logic       frame_done;

   int checks = 0;
   int errors = 0;
   int k = 0;

   logic [3:0] m_sh [8];
   logic [7:0] m_dp;
   logic       m_lz;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .CLK_FREQ_HZ (8000),
      .SCAN_HZ     (100),
      .GHOST_CYC   (GHOST),
      .SEG_ACT_LOW (1'b0),
      .SEL_ACT_LOW (1'b0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg0       (seg_in[0]),
      .seg1       (seg_in[1]),
      .seg2       (seg_in[2]),
      .seg3       (seg_in[3]),
      .seg4       (seg_in[4]),
      .seg5       (seg_in[5]),
      .seg6       (seg_in[6]),
      .seg7       (seg_in[7]),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .dig_sel    (dig_sel),
      .seg_out    (seg_out),
      .frame_done (frame_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   function automatic logic [6:0] ref_glyph(input logic [3:0] v);
      case (v)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   // One clock: the pins after edge k show the slot position of cycle k-1.
   task automatic step();
      int         c;
      int         cnt;
      int         idx;
      bit         blank;
      logic [7:0] e_sel;
      logic [7:0] e_seg;
      @(posedge clk);
      k++;
      #1;
      c     = k - 1;
      cnt   = c % DIV;
      idx   = (c / DIV) % 8;
      e_sel = 8'h00;
      e_seg = 8'h00;
      if (cnt >= GHOST) begin
         blank = m_lz && (idx >= 1);
         for (int j = idx; j < 8; j++)
            if (m_sh[j] != 4'd0) blank = 1'b0;
         e_sel = 8'(1 << idx);
         e_seg = {m_dp[idx], (blank ? 7'h00 : ref_glyph(m_sh[idx]))};
      end
      check("dig_sel", 32'(dig_sel), 32'(e_sel));
      check("seg_out", 32'(seg_out), 32'(e_seg));
      check("frame_done", 32'(frame_done), 32'((k % FRAME) == 0));
      if (k == 1 || (k % FRAME) == 0) begin
         m_sh = seg_in;
         m_dp = dp_in;
         m_lz = blank_lz;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to_phase(input int ph);
      for (int i = 0; i < FRAME; i++) begin
         if ((k % FRAME) == ph) break;
         step();
      end
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      #1;
      check("rst_sel", 32'(dig_sel), 32'h00);
      check("rst_seg", 32'(seg_out), 32'h00);
      check("rst_fd", 32'(frame_done), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst_hold_sel", 32'(dig_sel), 32'h00);
         check("rst_hold_seg", 32'(seg_out), 32'h00);
      end
      @(negedge clk);
      k    = 0;
      m_dp = '0;
      m_lz = 1'b0;
      for (int i = 0; i < 8; i++) m_sh[i] = 4'd0;
      rst_n = 1'b1;
   endtask

   task automatic set_digits(input logic [31:0] v);
      for (int i = 0; i < 8; i++) seg_in[i] = v[4*i +: 4];
   endtask

   initial begin
      set_digits(32'h7654_3210);
      dp_in    = 8'h00;
      blank_lz = 1'b0;
      #12;
      hold_reset();

      // plain scan of 0..7
      run(2 * FRAME);

      // leading-zero blanking: digits 7..0 = 0,0,0,0,0,1,0,5
      set_digits(32'h0000_0105);
      blank_lz = 1'b1;
      run(2 * FRAME);
      set_digits(32'h0000_0000);
      run(2 * FRAME);

      // coherency: seg3 changes during the digit-1 slot
      set_digits(32'h7654_4210);
      blank_lz = 1'b0;
      run_to_phase(0);
      run(15);
      seg_in[3] = 4'd9;
      run(2 * FRAME);

      // hex digits with decimal point
      seg_in[0] = 4'hA;
      seg_in[1] = 4'hF;
      dp_in     = 8'h02;
      run(2 * FRAME);

      // input change landing exactly on the snapshot edge
      run_to_phase(FRAME - 1);
      set_digits(32'h0000_00C0);
      blank_lz = 1'b1;
      run(2 * FRAME);

      // random traffic, biased toward zeros so blanking gets exercised
      for (int n = 0; n < 20 * FRAME; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 4))
               0: dp_in = 8'($urandom);
               1: blank_lz = 1'($urandom);
               2: for (int i = $urandom_range(0, 7); i < 8; i++) seg_in[i] = 4'd0;
               default: seg_in[$urandom_range(0, 7)] =
                           ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            endcase
         end
         step();
      end

      // reset in the middle of the digit-5 slot
      run_to_phase(55);
      #2;
      hold_reset();
      run(2 * FRAME);

      for (int n = 0; n < 4 * FRAME; n++) begin
         if ($urandom_range(0, 7) == 0) seg_in[$urandom_range(0, 7)] = 4'($urandom);
         if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
